// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I-subset core: FSM states, opcodes,
// ALU control codes and the datapath mux selects driven by the controller.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format depends only on the opcode, so it is valid in every state.
  function automatic logic [1:0] imm_src_of(input logic [6:0] opcode);
    case (opcode)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle. mem_ready is the only handshake: an access
// requested by the controller completes in the cycle mem_ready is high.
interface multicycle_ctrl_if;
  import ctrl_pkg::*;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       mem_ready;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic [2:0] ALU_control;
  logic       illegal_instr;
  logic       instr_done;
  state_t     state;

  modport master (
    input  opcode, funct3, funct7b5, Zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegWrite, ALU_control, illegal_instr, instr_done, state
  );

  modport slave (
    output opcode, funct3, funct7b5, Zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegWrite, ALU_control, illegal_instr, instr_done, state
  );

endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Maps ALUOp plus instruction fields onto the 3-bit ALU control code.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // bit 30 means SUB only for R-type; for addi it is immediate data.
          3'b000:  alu_control = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle core: fetch, decode, execute, writeback
// for lw, sw, R-type, I-type ALU, beq and jal, stalling on mem_ready.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  multicycle_ctrl_if.master   bus
);

  state_t     state;
  state_t     state_next;
  logic       pc_update;
  logic       branch;
  logic [1:0] alu_op;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next        = state;
    pc_update         = 1'b0;
    branch            = 1'b0;
    alu_op            = ALUOP_ADD;
    bus.AdrSrc        = 1'b0;
    bus.MemWrite      = 1'b0;
    bus.IRWrite       = 1'b0;
    bus.ResultSrc     = RES_ALUOUT;
    bus.ALUSrcA       = SRCA_PC;
    bus.ALUSrcB       = SRCB_RS2;
    bus.RegWrite      = 1'b0;
    bus.illegal_instr = 1'b0;
    bus.instr_done    = 1'b0;

    case (state)
      S_FETCH: begin
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
        bus.IRWrite   = bus.mem_ready;
        pc_update     = bus.mem_ready;
        if (bus.mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
        case (bus.opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTER;
          OP_I:         state_next = S_EXECUTEI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default: begin
            state_next        = S_FETCH;
            bus.illegal_instr = 1'b1;
            bus.instr_done    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_IMM;
        state_next  = (bus.opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        bus.AdrSrc = 1'b1;
        if (bus.mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        bus.ResultSrc  = RES_DATA;
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
        state_next     = S_FETCH;
      end
      S_MEMWRITE: begin
        // The write strobe stays up until memory accepts it.
        bus.AdrSrc     = 1'b1;
        bus.MemWrite   = 1'b1;
        bus.instr_done = bus.mem_ready;
        if (bus.mem_ready) state_next = S_FETCH;
      end
      S_EXECUTER: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_RS2;
        alu_op      = ALUOP_FUNCT;
        state_next  = S_ALUWB;
      end
      S_EXECUTEI: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_IMM;
        alu_op      = ALUOP_FUNCT;
        state_next  = S_ALUWB;
      end
      S_ALUWB: begin
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
        state_next     = S_FETCH;
      end
      S_BEQ: begin
        bus.ALUSrcA    = SRCA_RS1;
        bus.ALUSrcB    = SRCB_RS2;
        alu_op         = ALUOP_SUB;
        branch         = 1'b1;
        bus.instr_done = 1'b1;
        state_next     = S_FETCH;
      end
      S_JAL: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_FOUR;
        pc_update   = 1'b1;
        state_next  = S_ALUWB;
      end
      default: state_next = S_FETCH;
    endcase

    bus.PCWrite = pc_update | (branch & bus.Zero);

    // A reset cycle must never commit architectural state.
    if (reset) begin
      bus.PCWrite       = 1'b0;
      bus.MemWrite      = 1'b0;
      bus.IRWrite       = 1'b0;
      bus.RegWrite      = 1'b0;
      bus.illegal_instr = 1'b0;
      bus.instr_done    = 1'b0;
    end
  end

  assign bus.ImmSrc = imm_src_of(bus.opcode);
  assign bus.state  = state;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .op5         (bus.opcode[5]),
    .alu_control (bus.ALU_control)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by
// cycle and compares state and control outputs against hand-derived values.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   done_cnt;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial done_cnt = 0;
  always @(negedge clk) if (!reset && bus.instr_done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic z, input logic rdy);
    bus.opcode    = op;
    bus.funct3    = f3;
    bus.funct7b5  = f7;
    bus.Zero      = z;
    bus.mem_ready = rdy;
    #1;
  endtask

  initial begin
    int base;
    int cyc;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    set_in(7'b0, 3'b0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();

    // Reset: FETCH decode with writes suppressed even though mem_ready=1.
    check("rst_state", bus.state, S_FETCH);
    check("rst_irwrite", bus.IRWrite, 1'b0);
    check("rst_pcwrite", bus.PCWrite, 1'b0);
    check("rst_srcb", bus.ALUSrcB, 2'b10);
    check("rst_ressrc", bus.ResultSrc, 2'b10);

    // R-type sub: FETCH, DECODE, EXECUTER, ALUWB.
    reset = 1'b0;
    set_in(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b1);
    base = done_cnt;
    check("r_fetch_ir", bus.IRWrite, 1'b1);
    check("r_fetch_pc", bus.PCWrite, 1'b1);
    check("r_fetch_adr", bus.AdrSrc, 1'b0);
    tick();
    check("r_dec_state", bus.state, S_DECODE);
    check("r_dec_srca", bus.ALUSrcA, 2'b01);
    check("r_dec_alu", bus.ALU_control, 3'b000);
    tick();
    check("r_ex_state", bus.state, S_EXECUTER);
    check("r_ex_alu", bus.ALU_control, 3'b001);
    check("r_ex_srcb", bus.ALUSrcB, 2'b00);
    tick();
    check("r_wb_state", bus.state, S_ALUWB);
    check("r_wb_regwr", bus.RegWrite, 1'b1);
    tick();
    check("r_back_fetch", bus.state, S_FETCH);
    check("r_done_once", done_cnt - base, 1);

    // I-type with bit30 set: addi must still add; ori selects OR.
    set_in(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b1);
    tick();
    tick();
    check("i_ex_state", bus.state, S_EXECUTEI);
    check("i_addi_alu", bus.ALU_control, 3'b000);
    check("i_ex_imm", bus.ImmSrc, 2'b00);
    set_in(7'b0010011, 3'b110, 1'b0, 1'b0, 1'b1);
    check("i_ori_alu", bus.ALU_control, 3'b011);
    set_in(7'b0010011, 3'b010, 1'b0, 1'b0, 1'b1);
    check("i_slti_alu", bus.ALU_control, 3'b101);
    set_in(7'b0010011, 3'b111, 1'b0, 1'b0, 1'b1);
    check("i_andi_alu", bus.ALU_control, 3'b010);
    set_in(7'b0010011, 3'b001, 1'b0, 1'b0, 1'b1);
    check("i_other_alu", bus.ALU_control, 3'b000);
    tick();
    tick();
    check("i_back_fetch", bus.state, S_FETCH);

    // lw: 2 stalls in FETCH, 3 in MEMREAD, MEMWB on cycle 10.
    cyc = 1;
    for (int i = 0; i < 2; i++) begin
      set_in(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
      check("lw_stall_state", bus.state, S_FETCH);
      check("lw_stall_ir", bus.IRWrite, 1'b0);
      check("lw_stall_pc", bus.PCWrite, 1'b0);
      tick();
      cyc++;
    end
    set_in(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b1);
    check("lw_ready_ir", bus.IRWrite, 1'b1);
    check("lw_ready_pc", bus.PCWrite, 1'b1);
    tick();
    cyc++;
    check("lw_dec_state", bus.state, S_DECODE);
    tick();
    cyc++;
    check("lw_adr_state", bus.state, S_MEMADR);
    check("lw_adr_srca", bus.ALUSrcA, 2'b10);
    check("lw_adr_srcb", bus.ALUSrcB, 2'b01);
    tick();
    cyc++;
    for (int i = 0; i < 3; i++) begin
      set_in(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
      check("lw_rd_state", bus.state, S_MEMREAD);
      check("lw_rd_adr", bus.AdrSrc, 1'b1);
      tick();
      cyc++;
    end
    set_in(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b1);
    check("lw_rd_final", bus.state, S_MEMREAD);
    tick();
    cyc++;
    check("lw_wb_state", bus.state, S_MEMWB);
    check("lw_wb_cycle", cyc, 10);
    check("lw_wb_ressrc", bus.ResultSrc, 2'b01);
    check("lw_wb_regwr", bus.RegWrite, 1'b1);
    check("lw_wb_done", bus.instr_done, 1'b1);
    tick();

    // sw: MEMWRITE held 3 cycles (2 stalled) then FETCH.
    set_in(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
    check("sw_fetch_imm", bus.ImmSrc, 2'b01);
    tick();
    tick();
    check("sw_adr_state", bus.state, S_MEMADR);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(7'b0100011, 3'b010, 1'b0, 1'b0, (i == 2) ? 1'b1 : 1'b0);
      check("sw_wr_state", bus.state, S_MEMWRITE);
      check("sw_wr_memwr", bus.MemWrite, 1'b1);
      check("sw_wr_adr", bus.AdrSrc, 1'b1);
      check("sw_wr_imm", bus.ImmSrc, 2'b01);
      check("sw_wr_done", bus.instr_done, (i == 2) ? 1'b1 : 1'b0);
      check("sw_wr_regwr", bus.RegWrite, 1'b0);
      tick();
    end
    check("sw_back_fetch", bus.state, S_FETCH);

    // beq taken then not taken.
    for (int i = 0; i < 2; i++) begin
      set_in(7'b1100011, 3'b000, 1'b0, 1'b0, 1'b1);
      tick();
      check("beq_dec_imm", bus.ImmSrc, 2'b10);
      tick();
      set_in(7'b1100011, 3'b000, 1'b0, (i == 0) ? 1'b1 : 1'b0, 1'b1);
      check("beq_state", bus.state, S_BEQ);
      check("beq_pcwrite", bus.PCWrite, (i == 0) ? 1'b1 : 1'b0);
      check("beq_alu", bus.ALU_control, 3'b001);
      check("beq_done", bus.instr_done, 1'b1);
      tick();
      check("beq_back_fetch", bus.state, S_FETCH);
    end

    // Unsupported opcode: one-cycle illegal pulse in DECODE, no writes.
    set_in(7'b1110011, 3'b000, 1'b0, 1'b0, 1'b1);
    check("ill_fetch_flag", bus.illegal_instr, 1'b0);
    tick();
    check("ill_dec_state", bus.state, S_DECODE);
    check("ill_flag", bus.illegal_instr, 1'b1);
    check("ill_done", bus.instr_done, 1'b1);
    check("ill_regwr", bus.RegWrite, 1'b0);
    check("ill_memwr", bus.MemWrite, 1'b0);
    tick();
    check("ill_back_fetch", bus.state, S_FETCH);
    check("ill_flag_clear", bus.illegal_instr, 1'b0);

    // Reset while MEMWRITE strobes: write suppressed, FETCH next edge.
    set_in(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    tick();
    set_in(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
    check("rstw_pre_memwr", bus.MemWrite, 1'b1);
    reset = 1'b1;
    #1;
    check("rstw_memwr", bus.MemWrite, 1'b0);
    check("rstw_state_held", bus.state, S_MEMWRITE);
    tick();
    check("rstw_state", bus.state, S_FETCH);
    reset = 1'b0;

    // jal: FETCH, DECODE, JAL, ALUWB.
    set_in(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b1);
    tick();
    check("jal_dec_state", bus.state, S_DECODE);
    tick();
    check("jal_state", bus.state, S_JAL);
    check("jal_pcwrite", bus.PCWrite, 1'b1);
    check("jal_srca", bus.ALUSrcA, 2'b01);
    check("jal_srcb", bus.ALUSrcB, 2'b10);
    check("jal_imm", bus.ImmSrc, 2'b11);
    check("jal_regwr", bus.RegWrite, 1'b0);
    tick();
    check("jal_wb_state", bus.state, S_ALUWB);
    check("jal_wb_regwr", bus.RegWrite, 1'b1);
    tick();
    check("jal_back_fetch", bus.state, S_FETCH);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle RV32I-subset core. It sequences the shared 32-bit ALU, register file, PC and unified memory through fetch, decode, execute and writeback for lw, sw, R-type, I-type ALU, beq and jal.
- Drives ALU_control with the 3-bit encoding that the ALU decodes, and consumes the ALU's Zero flag for branches.
- Stalls on a memory ready handshake.

Parameters:
- None. Encodings are fixed by the shared package.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  latch the instruction register and OldPC
- ResultSrc  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALU_result
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 register
- ALUSrcB  out  2  00 = rs2 register, 01 = ImmExt, 10 = constant 4
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
- RegWrite  out  1  register file write enable
- ALU_control  out  3  ADD 000, SUB 001, AND 010, OR 011, SLT 101
- illegal_instr  out  1  one-cycle pulse in DECODE when the opcode is unsupported
- instr_done  out  1  one-cycle pulse in the final state of each instruction

Behaviour:
- State is a registered enum. All outputs are combinational from state, plus mem_ready, Zero and the instruction fields as noted below.
- Any output not listed for a state is 0, and ALUOp defaults to 00.
- Reset:
  - reset high at a clk edge forces state to FETCH.
  - While reset is high, PCWrite, MemWrite, IRWrite, RegWrite, illegal_instr and instr_done are forced to 0. The other outputs follow the FETCH decode.
  - Reset mid-instruction abandons the instruction. No write is issued in the reset cycle.
- PCWrite = PCUpdate | (Branch & Zero).
- Per-state outputs and transitions:
  - FETCH: AdrSrc=0, A=00, B=10, ALUOp=00, ResultSrc=10. IRWrite and PCUpdate equal mem_ready. Go to DECODE when mem_ready, else stay.
  - DECODE: A=01, B=01, ALUOp=00 (computes the branch target). Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other opcode -> FETCH, with illegal_instr=1 and instr_done=1.
  - MEMADR: A=10, B=01, ALUOp=00. Go to MEMREAD if opcode is lw, else MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Go to MEMWB when mem_ready, else stay.
  - MEMWB: ResultSrc=01, RegWrite=1, instr_done=1. Go to FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, held high until mem_ready. Go to FETCH when mem_ready, asserting instr_done in that cycle.
  - EXECUTER: A=10, B=00, ALUOp=10. Go to ALUWB.
  - EXECUTEI: A=10, B=01, ALUOp=10. Go to ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, instr_done=1. Go to FETCH.
  - BEQ: A=10, B=00, ALUOp=01, ResultSrc=00, Branch=1, instr_done=1. Go to FETCH.
  - JAL: A=01, B=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Go to ALUWB.
- ImmSrc is decoded from opcode in every state: lw and I-type -> 00, sw -> 01, beq -> 10, jal -> 11, anything else -> 00.
- ALU decoder:
  - ALUOp 00 -> ADD.
  - ALUOp 01 -> SUB.
  - ALUOp 10, decoded on funct3:
    - 000 -> SUB if (funct7b5 & opcode[5]), else ADD
    - 010 -> SLT
    - 110 -> OR
    - 111 -> AND
    - any other funct3 -> ADD, with no error flag.
  - ALUOp 11 -> ADD.
- Latency, with mem_ready=1 every cycle:
  - lw 5 cycles, sw 4, R-type/I-type 4, beq 3, jal 4.
  - Each stalled cycle adds 1.

Decomposition:
- Package ctrl_pkg holds:
  - the state_t enum
  - opcode localparams (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL)
  - the ALU_control codes (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT), which the ALU shares
  - the ALUOp, ResultSrc, ALUSrcA/B and ImmSrc encodings.
- One sub-module, alu_decoder, combinational: ALUOp, funct3, funct7b5 and opcode[5] in; ALU_control out.

Test Plan:
- Reset, then a 0110011 R-type (funct3=000, funct7b5=1) with mem_ready=1 -> state sequence FETCH, DECODE, EXECUTER, ALUWB. ALU_control=001 in EXECUTER, RegWrite=1 in ALUWB, instr_done pulses once.
- lw with mem_ready low for 2 cycles in FETCH and 3 in MEMREAD -> IRWrite/PCWrite pulse only on the ready cycle, MEMWB reached at cycle 10, ResultSrc=01 with RegWrite=1.
- sw with mem_ready=0 for 2 cycles in MEMWRITE -> MemWrite held high for 3 cycles with AdrSrc=1, ImmSrc=01 throughout, then FETCH.
- beq with Zero=1, then a second beq with Zero=0 -> PCWrite=1 in BEQ only for the first. ALU_control=001 and ImmSrc=10 for both.
- Opcode 1110011 -> illegal_instr=1 for exactly one DECODE cycle, returns to FETCH, no RegWrite or MemWrite.
- reset asserted in MEMWRITE while MemWrite is high -> MemWrite=0 in the reset cycle, state FETCH on the next edge. jal afterwards gives FETCH, DECODE, JAL, ALUWB with PCWrite=1 in JAL.
